// File: rtl/alarm_clock_pkg.sv
// Shared types and BCD constants for the alarm clock user-interface stage.
// Latency: none (types and pure functions only); no flow control.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ED_HH  = 3'd1,
    ST_ED_MM  = 3'd2,
    ST_ED_SS  = 3'd3,
    ST_ED_PM  = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  localparam logic [2:0] FLD_NONE = 3'd0;
  localparam logic [2:0] FLD_HH   = 3'd1;
  localparam logic [2:0] FLD_MM   = 3'd2;
  localparam logic [2:0] FLD_SS   = 3'd3;
  localparam logic [2:0] FLD_PM   = 3'd4;

  localparam logic [7:0] HH_MIN = 8'h01;
  localparam logic [7:0] HH_MAX = 8'h12;
  localparam logic [7:0] MS_MIN = 8'h00;
  localparam logic [7:0] MS_MAX = 8'h59;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Seeds must land inside the field range, otherwise the wrap logic would walk garbage.
  function automatic logic [7:0] seed_hh(input logic [7:0] v);
    return (bcd_ok(v) && (v >= HH_MIN) && (v <= HH_MAX)) ? v : HH_MAX;
  endfunction

  function automatic logic [7:0] seed_ms(input logic [7:0] v);
    return (bcd_ok(v) && (v <= MS_MAX)) ? v : MS_MIN;
  endfunction

  function automatic logic [2:0] field_of(input state_e s);
    case (s)
      ST_ED_HH: return FLD_HH;
      ST_ED_MM: return FLD_MM;
      ST_ED_SS: return FLD_SS;
      ST_ED_PM: return FLD_PM;
      default:  return FLD_NONE;
    endcase
  endfunction

  function automatic logic is_edit(input state_e s);
    return (s == ST_ED_HH) || (s == ST_ED_MM) || (s == ST_ED_SS) || (s == ST_ED_PM);
  endfunction

endpackage

// File: rtl/bcd_wrap_step.sv
// One BCD increment/decrement step with wrap-around inside [MIN, MAX].
// Latency: combinational; inc and dec together leave the value unchanged.
module bcd_wrap_step #(
  parameter logic [7:0] MIN = 8'h00,
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] next
);

  always_comb begin
    next = val;
    if (inc && !dec) begin
      if (val >= MAX) begin
        next = MIN;
      end else if (val[3:0] >= 4'd9) begin
        next = {val[7:4] + 4'd1, 4'd0};
      end else begin
        next = val + 8'd1;
      end
    end else if (dec && !inc) begin
      if (val <= MIN) begin
        next = MAX;
      end else if (val[3:0] == 4'd0) begin
        next = {val[7:4] - 4'd1, 4'd9};
      end else begin
        next = val - 8'd1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Push-button edit session over HH/MM/SS/PM; commits with a one-cycle load strobe.
// Latency: 1 cycle from button edge to register update; no backpressure (clock core always samples).
module time_set_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_CYC = 30,
  parameter int REPEAT_DLY  = 2
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_cancel,
  input  logic       sel_alarm,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  input  logic       cur_pm,
  output logic [7:0] hh_load,
  output logic [7:0] mm_load,
  output logic [7:0] ss_load,
  output logic       pm_load,
  output logic       load_time,
  output logic       load_alarm,
  output logic       editing,
  output logic [2:0] edit_field,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(REPEAT_DLY + 2);

  state_e          state_q, state_d;
  logic            target_q, target_d;
  logic [7:0]      hh_q, hh_d;
  logic [7:0]      mm_q, mm_d;
  logic [7:0]      ss_q, ss_d;
  logic            pm_q, pm_d;
  logic            load_time_q, load_time_d;
  logic            load_alarm_q, load_alarm_d;
  logic            editing_q, editing_d;
  logic [2:0]      field_q, field_d;
  logic            blink_q, blink_d;
  logic [3:0]      btn_prev_q, btn_prev_d;
  logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [3:0] btn_now;
  logic [3:0] btn_edge;
  logic       set_e, inc_e, dec_e, cancel_e;
  logic       in_edit;
  logic       rpt_ready;
  logic       step_req, step_inc, step_dec;
  logic       tmo_hit;
  logic [7:0] ms_val;
  logic [7:0] hh_next, ms_next;

  assign btn_now  = {btn_set, btn_inc, btn_dec, btn_cancel};
  assign btn_edge = btn_now & ~btn_prev_q;
  assign set_e    = btn_edge[3];
  assign inc_e    = btn_edge[2];
  assign dec_e    = btn_edge[1];
  assign cancel_e = btn_edge[0];
  assign in_edit  = is_edit(state_q);

  // A held button steps on its edge, then again every cycle once the hold delay has elapsed.
  assign rpt_ready = (rpt_cnt_q == RW'(REPEAT_DLY));
  assign step_req  = inc_e | dec_e | ((btn_inc | btn_dec) & rpt_ready);
  assign step_inc  = step_req & btn_inc & ~btn_dec;
  assign step_dec  = step_req & btn_dec & ~btn_inc;
  assign tmo_hit   = in_edit && (btn_edge == 4'b0000) && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  assign ms_val = (state_q == ST_ED_SS) ? ss_q : mm_q;

  bcd_wrap_step #(.MIN(HH_MIN), .MAX(HH_MAX)) u_hh_step (
    .val  (hh_q),
    .inc  (step_inc),
    .dec  (step_dec),
    .next (hh_next)
  );

  bcd_wrap_step #(.MIN(MS_MIN), .MAX(MS_MAX)) u_ms_step (
    .val  (ms_val),
    .inc  (step_inc),
    .dec  (step_dec),
    .next (ms_next)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    pm_d       = pm_q;
    btn_prev_d = btn_now;

    if (!in_edit || !(btn_inc || btn_dec) || inc_e || dec_e) begin
      rpt_cnt_d = '0;
    end else if (!rpt_ready) begin
      rpt_cnt_d = rpt_cnt_q + RW'(1);
    end else begin
      rpt_cnt_d = rpt_cnt_q;
    end

    if (!in_edit || (btn_edge != 4'b0000) || tmo_hit) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (set_e) begin
          target_d = sel_alarm;
          hh_d     = seed_hh(cur_hh);
          mm_d     = seed_ms(cur_mm);
          ss_d     = seed_ms(cur_ss);
          pm_d     = cur_pm;
          state_d  = ST_ED_HH;
        end
      end
      ST_ED_HH, ST_ED_MM, ST_ED_SS, ST_ED_PM: begin
        if (cancel_e || tmo_hit) begin
          state_d = ST_IDLE;
        end else if (set_e) begin
          case (state_q)
            ST_ED_HH: state_d = ST_ED_MM;
            ST_ED_MM: state_d = ST_ED_SS;
            ST_ED_SS: state_d = ST_ED_PM;
            default:  state_d = ST_COMMIT;
          endcase
        end else begin
          case (state_q)
            ST_ED_HH: hh_d = hh_next;
            ST_ED_MM: mm_d = ms_next;
            ST_ED_SS: ss_d = ms_next;
            default:  pm_d = pm_q ^ (step_inc | step_dec);
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered so they line up with the state they describe.
    editing_d    = is_edit(state_d);
    field_d      = field_of(state_d);
    blink_d      = editing_d & ~blink_q;
    load_time_d  = (state_d == ST_COMMIT) & ~target_q;
    load_alarm_d = (state_d == ST_COMMIT) & target_q;
  end

  always_ff @(posedge clk_1s) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      target_q     <= 1'b0;
      hh_q         <= HH_MAX;
      mm_q         <= MS_MIN;
      ss_q         <= MS_MIN;
      pm_q         <= 1'b0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      editing_q    <= 1'b0;
      field_q      <= FLD_NONE;
      blink_q      <= 1'b0;
      btn_prev_q   <= 4'b0000;
      rpt_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      hh_q         <= hh_d;
      mm_q         <= mm_d;
      ss_q         <= ss_d;
      pm_q         <= pm_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      editing_q    <= editing_d;
      field_q      <= field_d;
      blink_q      <= blink_d;
      btn_prev_q   <= btn_prev_d;
      rpt_cnt_q    <= rpt_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign hh_load    = hh_q;
  assign mm_load    = mm_q;
  assign ss_load    = ss_q;
  assign pm_load    = pm_q;
  assign load_time  = load_time_q;
  assign load_alarm = load_alarm_q;
  assign editing    = editing_q;
  assign edit_field = field_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed vector table, corner sequences, then random buttons vs a decimal model.
module tb_time_set_ctrl;

  localparam int TO = 30;
  localparam int RD = 2;

  localparam logic [3:0] B0  = 4'b0000;
  localparam logic [3:0] SET = 4'b1000;
  localparam logic [3:0] INC = 4'b0100;
  localparam logic [3:0] DEC = 4'b0010;
  localparam logic [3:0] CAN = 4'b0001;

  logic       clk_1s = 1'b0;
  logic       reset, btn_set, btn_inc, btn_dec, btn_cancel, sel_alarm, cur_pm;
  logic [7:0] cur_hh, cur_mm, cur_ss;
  logic [7:0] hh_load, mm_load, ss_load;
  logic       pm_load, load_time, load_alarm, editing, blink;
  logic [2:0] edit_field;

  always #5 clk_1s = ~clk_1s;

  time_set_ctrl #(.TIMEOUT_CYC(TO), .REPEAT_DLY(RD)) dut (
    .clk_1s     (clk_1s),
    .reset      (reset),
    .btn_set    (btn_set),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_cancel (btn_cancel),
    .sel_alarm  (sel_alarm),
    .cur_hh     (cur_hh),
    .cur_mm     (cur_mm),
    .cur_ss     (cur_ss),
    .cur_pm     (cur_pm),
    .hh_load    (hh_load),
    .mm_load    (mm_load),
    .ss_load    (ss_load),
    .pm_load    (pm_load),
    .load_time  (load_time),
    .load_alarm (load_alarm),
    .editing    (editing),
    .edit_field (edit_field),
    .blink      (blink)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: fields kept as plain decimal numbers; mode 0 idle, 1..4 = HH/MM/SS/PM, 5 commit.
  int       m_mode, m_h, m_m, m_s, m_quiet, m_hold;
  bit       m_tgt, m_pm, m_lt, m_la, m_blink;
  bit [3:0] m_prev;

  function automatic int seed(input logic [7:0] c, input int lo, input int hi, input int dflt);
    int v;
    if (c[7:4] > 4'd9 || c[3:0] > 4'd9) return dflt;
    v = int'(c[7:4]) * 10 + int'(c[3:0]);
    return (v < lo || v > hi) ? dflt : v;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic model_step();
    bit [3:0] lv, e;
    bit was_edit, timeout;
    int d;
    lv = {btn_set, btn_inc, btn_dec, btn_cancel};
    if (reset) begin
      m_mode = 0; m_tgt = 0; m_h = 12; m_m = 0; m_s = 0; m_pm = 0;
      m_lt = 0; m_la = 0; m_blink = 0; m_prev = 0; m_quiet = 0; m_hold = 0;
      return;
    end
    e = lv & ~m_prev;
    m_prev = lv;
    was_edit = (m_mode >= 1 && m_mode <= 4);
    if (!was_edit || e != 0) m_quiet = 0; else m_quiet++;
    timeout = was_edit && m_quiet >= TO;
    if (!was_edit || !(btn_inc || btn_dec) || e[2] || e[1]) m_hold = 0;
    else if (m_hold < 1000) m_hold++;
    m_lt = 0; m_la = 0;
    if (m_mode == 5) m_mode = 0;
    else if (m_mode == 0) begin
      if (e[3]) begin
        m_tgt = sel_alarm;
        m_h = seed(cur_hh, 1, 12, 12);
        m_m = seed(cur_mm, 0, 59, 0);
        m_s = seed(cur_ss, 0, 59, 0);
        m_pm = cur_pm;
        m_mode = 1;
      end
    end else if (e[0] || timeout) m_mode = 0;
    else if (e[3]) begin
      m_mode++;
      if (m_mode == 5) begin m_lt = !m_tgt; m_la = m_tgt; end
    end else if ((e[2] || e[1] || m_hold > RD) && (btn_inc != btn_dec)) begin
      d = btn_inc ? 1 : -1;
      case (m_mode)
        1: m_h = ((m_h - 1 + d + 12) % 12) + 1;
        2: m_m = (m_m + d + 60) % 60;
        3: m_s = (m_s + d + 60) % 60;
        default: m_pm = !m_pm;
      endcase
    end
    if (m_mode >= 5 || m_mode == 0) m_quiet = 0;
    m_blink = (m_mode >= 1 && m_mode <= 4) ? !m_blink : 1'b0;
  endtask

  function automatic logic [31:0] exp_vec();
    bit ed;
    ed = (m_mode >= 1 && m_mode <= 4);
    return {bcd(m_h), bcd(m_m), bcd(m_s), m_pm, m_lt, m_la, ed, ed ? 3'(m_mode) : 3'd0, m_blink};
  endfunction

  task automatic tick();
    @(posedge clk_1s);
    model_step();
    #1;
    chk("model", {hh_load, mm_load, ss_load, pm_load, load_time, load_alarm, editing, edit_field, blink},
        exp_vec());
  endtask

  task automatic drive(input logic [3:0] b);
    {btn_set, btn_inc, btn_dec, btn_cancel} = b;
    tick();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] b;
    logic       sel;
    logic [7:0] chh, cmm, ehh, emm, ess;
    logic       epm;
    logic [2:0] efld;
    logic       elt, ela;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] b, input logic sel, input logic [7:0] chh,
                              input logic [7:0] cmm, input logic [7:0] ehh, input logic [7:0] emm,
                              input logic [7:0] ess, input logic epm, input logic [2:0] efld,
                              input logic elt, input logic ela);
    vec_t v;
    v.rst = rst; v.b = b; v.sel = sel; v.chh = chh; v.cmm = cmm; v.ehh = ehh; v.emm = emm;
    v.ess = ess; v.epm = epm; v.efld = efld; v.elt = elt; v.ela = ela;
    return v;
  endfunction

  function automatic logic [3:0] flip(input logic [3:0] cur);
    logic [3:0] n;
    n = cur;
    if ($urandom_range(5) == 0) n[3] = ~n[3];
    if ($urandom_range(4) == 0) n[2] = ~n[2];
    if ($urandom_range(7) == 0) n[1] = ~n[1];
    if ($urandom_range(39) == 0) n[0] = ~n[0];
    return n;
  endfunction

  function automatic logic [7:0] rnd_bcd();
    if ($urandom_range(3) == 0) return 8'($urandom);
    return {4'($urandom_range(5)), 4'($urandom_range(9))};
  endfunction

  initial begin
    reset = 1; {btn_set, btn_inc, btn_dec, btn_cancel} = B0;
    sel_alarm = 0; cur_hh = 8'h11; cur_mm = 8'h59; cur_ss = 8'h58; cur_pm = 1;

    tv.push_back(mk(1, B0,  0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h59, 8'h12, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h59, 8'h01, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h01, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h59, 8'h02, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h02, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, DEC, 0, 8'h11, 8'h59, 8'h01, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h01, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, DEC, 0, 8'h11, 8'h59, 8'h12, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h59, 8'h12, 8'h59, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h59, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, SET | INC, 0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 1, 3, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 1, 3, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 1, 4, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 1, 4, 0, 0));
    tv.push_back(mk(0, DEC, 0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 0, 4, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 0, 4, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 0, 0, 1, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h12, 8'h00, 8'h58, 0, 0, 0, 0));
    tv.push_back(mk(0, SET, 1, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  1, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 3, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 3, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 4, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 4, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 0, 0, 1));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h59, 8'h11, 8'h59, 8'h58, 1, 0, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h07, 8'h11, 8'h07, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h07, 8'h11, 8'h07, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h11, 8'h07, 8'h11, 8'h07, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h07, 8'h11, 8'h07, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h07, 8'h11, 8'h08, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h07, 8'h11, 8'h08, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h07, 8'h11, 8'h08, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h07, 8'h11, 8'h09, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h07, 8'h11, 8'h10, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, INC, 0, 8'h11, 8'h07, 8'h11, 8'h11, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h07, 8'h11, 8'h11, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, INC | DEC, 0, 8'h11, 8'h07, 8'h11, 8'h11, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h07, 8'h11, 8'h11, 8'h58, 1, 2, 0, 0));
    tv.push_back(mk(1, B0,  0, 8'h11, 8'h07, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h11, 8'h07, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(0, SET, 0, 8'h00, 8'h7A, 8'h12, 8'h00, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h00, 8'h7A, 8'h12, 8'h00, 8'h58, 1, 1, 0, 0));
    tv.push_back(mk(0, CAN, 0, 8'h00, 8'h7A, 8'h12, 8'h00, 8'h58, 1, 0, 0, 0));
    tv.push_back(mk(0, B0,  0, 8'h00, 8'h7A, 8'h12, 8'h00, 8'h58, 1, 0, 0, 0));

    foreach (tv[i]) begin
      reset = tv[i].rst; sel_alarm = tv[i].sel; cur_hh = tv[i].chh; cur_mm = tv[i].cmm;
      drive(tv[i].b);
      chk($sformatf("vec%0d", i), {hh_load, mm_load, ss_load, pm_load, edit_field, load_time, load_alarm},
          {tv[i].ehh, tv[i].emm, tv[i].ess, tv[i].epm, tv[i].efld, tv[i].elt, tv[i].ela});
    end

    // Silent timeout after TO quiet cycles in the seconds field.
    cur_hh = 8'h11; cur_mm = 8'h59;
    drive(SET); drive(B0); drive(SET); drive(B0); drive(SET);
    chk("tmo_enter_ss", 32'(edit_field), 32'd3);
    for (int k = 1; k <= TO; k++) begin
      drive(B0);
      chk($sformatf("tmo_strobe%0d", k), {load_time, load_alarm}, 2'b00);
      if (k == TO - 1) chk("tmo_still_ss", 32'(edit_field), 32'd3);
    end
    chk("tmo_idle", {editing, edit_field}, 4'b0000);

    // Cancel from the PM field.
    drive(SET); drive(B0); drive(SET); drive(B0); drive(SET); drive(B0); drive(SET); drive(B0);
    chk("cancel_in_pm", 32'(edit_field), 32'd4);
    drive(CAN);
    chk("cancel_idle", {editing, edit_field, load_time, load_alarm}, 6'b000000);
    drive(B0);
    chk("cancel_no_strobe", {load_time, load_alarm}, 2'b00);

    // Random buttons with persistence so holds and auto-repeat occur.
    begin
      logic [3:0] lv;
      lv = B0;
      for (int n = 0; n < 4000; n++) begin
        reset = ($urandom_range(499) == 0);
        sel_alarm = 1'($urandom);
        cur_hh = rnd_bcd(); cur_mm = rnd_bcd(); cur_ss = rnd_bcd(); cur_pm = 1'($urandom);
        lv = flip(lv);
        drive(lv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
